// File: rtl/miter_vector_checker.sv
// miter_vector_checker: sweeps every input vector into a golden/revised pair (vec_out -> g_out/f_out), compares them and reports busy/done/equiv/cex_valid/cex_vec/cex_diff/mismatch_cnt
module miter_vector_checker #(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 2,
  parameter int SETTLE     = 0,
  parameter int STOP_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  g_out,
  input  logic [N_OUT-1:0]  f_out,
  output logic              busy,
  output logic              done,
  output logic              equiv,
  output logic              cex_valid,
  output logic [N_IN-1:0]   cex_vec,
  output logic [N_OUT-1:0]  cex_diff,
  output logic [N_IN:0]     mismatch_cnt
);
  localparam int HW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, CHECK, FIN} state_t;
  localparam state_t FIRST = SETTLE > 0 ? HOLD : CHECK;
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic [N_OUT-1:0] diff;
  logic mis, fin;
  assign diff = f_out ^ g_out;
  assign mis = |diff;
  assign fin = (&vec_out) || (STOP_FIRST != 0 && mis);
  assign busy = state == HOLD || state == CHECK;
  assign done = state == FIN;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FIRST : IDLE;
      HOLD:    state_nx = abort ? IDLE : hold_cnt == HW'(1) ? CHECK : HOLD;
      CHECK:   state_nx = abort ? IDLE : fin ? FIN : FIRST;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out      <= '0;
      hold_cnt     <= '0;
      equiv        <= 1'b0;
      cex_valid    <= 1'b0;
      cex_vec      <= '0;
      cex_diff     <= '0;
      mismatch_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        vec_out      <= '0;
        hold_cnt     <= HW'(SETTLE);
        equiv        <= 1'b0;
        cex_valid    <= 1'b0;
        cex_vec      <= '0;
        cex_diff     <= '0;
        mismatch_cnt <= '0;
      end
    end else if (abort) begin
      equiv <= 1'b0;
    end else if (state == HOLD) begin
      hold_cnt <= hold_cnt - HW'(1);
    end else if (state == CHECK) begin
      if (mis) begin
        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
        if (!cex_valid) begin
          cex_valid <= 1'b1;
          cex_vec   <= vec_out;
          cex_diff  <= diff;
        end
      end
      if (fin) begin
        equiv <= mismatch_cnt == '0 && !mis;
      end else begin
        vec_out  <= vec_out + N_IN'(1);
        hold_cnt <= HW'(SETTLE);
      end
    end
  end
endmodule

// File: tb/tb_miter_vector_checker.sv
// tb_miter_vector_checker: randomized miter runs on three parameterizations checked against a vector-sweep model
module tb_miter_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [3];
  logic abort [3];
  logic [2:0] vec [3];
  logic [2:0] cex_vec [3];
  logic [1:0] g [3];
  logic [1:0] f [3];
  logic [1:0] cex_diff [3];
  logic busy [3];
  logic done [3];
  logic equiv [3];
  logic cex_valid [3];
  logic [3:0] cnt [3];
  logic [1:0] mask [3][8];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  function automatic logic [1:0] gold(logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    return {(a & b & c) | ~(b | c), a & b & (a ^ c)};
  endfunction
  for (genvar j = 0; j < 3; j++) begin : g_dut
    assign g[j] = gold(vec[j]);
    assign f[j] = g[j] ^ mask[j][vec[j]];
    miter_vector_checker #(.N_IN(3), .N_OUT(2), .SETTLE(j == 1 ? 2 : 0), .STOP_FIRST(j == 2 ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[j]), .abort(abort[j]), .vec_out(vec[j]),
      .g_out(g[j]), .f_out(f[j]), .busy(busy[j]), .done(done[j]), .equiv(equiv[j]),
      .cex_valid(cex_valid[j]), .cex_vec(cex_vec[j]), .cex_diff(cex_diff[j]), .mismatch_cnt(cnt[j]));
  end
  task automatic set_mode(int k, int mode);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      logic [1:0] gv, r;
      vv = 3'(v);
      gv = gold(vv);
      r = mode == 1 ? {gv[1], vv[2] & vv[1]} :
          mode == 2 ? {1'b0, gv[0]} :
          mode == 3 ? gv ^ (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00) : gv;
      mask[k][v] = gv ^ r;
    end
  endtask
  task automatic model(int k, bit stop, int lim, output int cnt_e, output logic [2:0] cv,
                       output logic [1:0] cd, output logic cval, output int last);
    cnt_e = 0; cv = '0; cd = '0; cval = 1'b0; last = 7;
    for (int v = 0; v < lim; v++) begin
      if (mask[k][v] != 2'b00) begin
        cnt_e++;
        if (!cval) begin cval = 1'b1; cv = 3'(v); cd = mask[k][v]; end
        if (stop) begin last = v; break; end
      end
    end
  endtask
  task automatic run(int k, int poke);
    int s, cnt_e, last, n;
    logic [2:0] cv;
    logic [1:0] cd;
    logic cval;
    s = k == 1 ? 2 : 0;
    model(k, k == 2, 8, cnt_e, cv, cd, cval, last);
    @(negedge clk) start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    n = 0;
    while (done[k] !== 1'b1 && n <= 200) begin
      checks++;
      if (busy[k] !== 1'b1 || vec[k] !== 3'(n / (s + 1))) begin
        failures++;
        $display("FAIL run_seq k=%0d cycle=%0d got busy=%b vec=%0d exp busy=1 vec=%0d", k, n, busy[k], vec[k], n / (s + 1));
      end
      start[k] = n == poke;
      @(posedge clk); #1 n++;
    end
    start[k] = 1'b1;
    checks++;
    if (n !== (last + 1) * (s + 1)) begin
      failures++;
      $display("FAIL run_latency k=%0d got=%0d exp=%0d", k, n, (last + 1) * (s + 1));
    end
    checks++;
    if (busy[k] !== 1'b0 || vec[k] !== 3'(last)) begin
      failures++;
      $display("FAIL run_fin k=%0d got busy=%b vec=%0d exp busy=0 vec=%0d", k, busy[k], vec[k], last);
    end
    checks++;
    if (equiv[k] !== (cnt_e == 0) || cnt[k] !== 4'(cnt_e)) begin
      failures++;
      $display("FAIL run_count k=%0d got equiv=%b cnt=%0d exp equiv=%b cnt=%0d", k, equiv[k], cnt[k], cnt_e == 0, cnt_e);
    end
    checks++;
    if (cex_valid[k] !== cval || cex_vec[k] !== cv || cex_diff[k] !== cd) begin
      failures++;
      $display("FAIL run_cex k=%0d got v=%b vec=%0d diff=%b exp v=%b vec=%0d diff=%b", k, cex_valid[k], cex_vec[k], cex_diff[k], cval, cv, cd);
    end
    @(posedge clk); #1 start[k] = 1'b0;
    checks++;
    if (done[k] !== 1'b0 || busy[k] !== 1'b0 || vec[k] !== 3'(last)) begin
      failures++;
      $display("FAIL run_idle k=%0d got done=%b busy=%b vec=%0d exp done=0 busy=0 vec=%0d", k, done[k], busy[k], vec[k], last);
    end
    checks++;
    if (equiv[k] !== (cnt_e == 0) || cnt[k] !== 4'(cnt_e) || cex_vec[k] !== cv) begin
      failures++;
      $display("FAIL run_hold k=%0d got equiv=%b cnt=%0d cex=%0d exp equiv=%b cnt=%0d cex=%0d", k, equiv[k], cnt[k], cex_vec[k], cnt_e == 0, cnt_e, cv);
    end
  endtask
  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({vec[k], busy[k], done[k], equiv[k], cex_valid[k], cex_vec[k], cex_diff[k], cnt[k]} !== 16'h0) begin
        failures++;
        $display("FAIL reset_vals k=%0d got=%h exp=0", k, {vec[k], busy[k], done[k], equiv[k], cex_valid[k], cex_vec[k], cex_diff[k], cnt[k]});
      end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_equiv();
    set_mode(0, 0);
    run(0, -1);
  endtask
  task automatic test_y1_fault();
    set_mode(0, 1);
    run(0, -1);
    checks++;
    if (equiv[0] !== 1'b0 || cnt[0] !== 4'd1 || cex_vec[0] !== 3'b111 || cex_diff[0] !== 2'b01) begin
      failures++;
      $display("FAIL y1_fault got equiv=%b cnt=%0d cex=%b diff=%b exp equiv=0 cnt=1 cex=111 diff=01", equiv[0], cnt[0], cex_vec[0], cex_diff[0]);
    end
  endtask
  task automatic test_stop_first();
    set_mode(2, 2);
    run(2, -1);
    checks++;
    if (equiv[2] !== 1'b0 || cnt[2] !== 4'd1 || cex_vec[2] !== 3'b000 || cex_diff[2] !== 2'b10) begin
      failures++;
      $display("FAIL stop_first got equiv=%b cnt=%0d cex=%b diff=%b exp equiv=0 cnt=1 cex=000 diff=10", equiv[2], cnt[2], cex_vec[2], cex_diff[2]);
    end
  endtask
  task automatic test_settle();
    set_mode(1, 0);
    run(1, -1);
  endtask
  task automatic test_random();
    repeat (9) begin
      int k;
      k = $urandom_range(0, 2);
      set_mode(k, 3);
      run(k, -1);
    end
  endtask
  task automatic test_abort();
    int n, cnt_e, last;
    logic [2:0] cv;
    logic [1:0] cd;
    logic cval;
    set_mode(0, 3);
    mask[0][1] = 2'b11;
    model(0, 1'b0, 4, cnt_e, cv, cd, cval, last);
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    n = 0;
    while (vec[0] !== 3'd4 && n < 20) begin @(posedge clk); #1 n++; end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL abort_reach got=%0d exp=4", n);
    end
    abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || equiv[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_ctrl got busy=%b done=%b equiv=%b exp 0 0 0", busy[0], done[0], equiv[0]);
    end
    checks++;
    if (cnt[0] !== 4'(cnt_e) || cex_valid[0] !== cval || cex_vec[0] !== cv || cex_diff[0] !== cd) begin
      failures++;
      $display("FAIL abort_partial got cnt=%0d v=%b cex=%0d diff=%b exp cnt=%0d v=%b cex=%0d diff=%b", cnt[0], cex_valid[0], cex_vec[0], cex_diff[0], cnt_e, cval, cv, cd);
    end
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL abort_nodone got done=%b busy=%b exp 0 0", done[0], busy[0]);
      end
    end
    set_mode(0, 3);
    run(0, -1);
  endtask
  task automatic test_back_to_back();
    set_mode(1, 3);
    run(1, 5);
    set_mode(0, 3);
    run(0, 3);
  endtask
  task automatic test_async_reset();
    set_mode(1, 3);
    @(negedge clk) start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({vec[k], busy[k], done[k], equiv[k], cex_valid[k], cex_vec[k], cex_diff[k], cnt[k]} !== 16'h0) begin
        failures++;
        $display("FAIL async_reset k=%0d got=%h exp=0", k, {vec[k], busy[k], done[k], equiv[k], cex_valid[k], cex_vec[k], cex_diff[k], cnt[k]});
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
        failures++;
        $display("FAIL reset_nodone got done=%b busy=%b exp 0 0", done[1], busy[1]);
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      for (int v = 0; v < 8; v++) mask[k][v] = 2'b00;
    end
    test_reset();
    test_equiv();
    test_y1_fault();
    test_stop_first();
    test_settle();
    test_random();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
